// File: rtl/fft_pkg.sv
// Shared FFT definitions: sizes, complex sample type, bin bit reversal and unload states.
// The streamer and the FFT core both import this package.
package fft_pkg;

   localparam int unsigned FFT_N     = 4096;
   localparam int unsigned FFT_LOG2N = 12;
   localparam int unsigned SAMPLE_W  = 16;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] re;
      logic signed [SAMPLE_W-1:0] im;
   } cplx_t;

   typedef struct packed {
      cplx_t                  data;
      logic [FFT_LOG2N-1:0]   index;
      logic                   last;
   } fifo_entry_t;

   typedef enum logic [1:0] {StIdle, StStream, StDrain} unload_state_e;

   function automatic logic [FFT_LOG2N-1:0] bit_reverse(input logic [FFT_LOG2N-1:0] a);
      logic [FFT_LOG2N-1:0] r;
      for (int i = 0; i < FFT_LOG2N; i++) begin
         r[i] = a[FFT_LOG2N-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_result_streamer_if.sv
// RAM read port and output sample stream of the FFT result streamer.
// master = streamer side, slave = RAM plus downstream sink.
interface fft_result_streamer_if
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N  = FFT_LOG2N,
   parameter int unsigned DATA_W = SAMPLE_W
);
   logic                     ram_own;
   logic                     ram_rd_en;
   logic [LOG2N-1:0]         ram_addr;
   logic signed [DATA_W-1:0] ram_dout_real;
   logic signed [DATA_W-1:0] ram_dout_imag;
   logic                     m_valid;
   logic                     m_ready;
   logic signed [DATA_W-1:0] m_real;
   logic signed [DATA_W-1:0] m_imag;
   logic [LOG2N-1:0]         m_index;
   logic                     m_last;

   modport master (
      output ram_own, ram_rd_en, ram_addr,
      input  ram_dout_real, ram_dout_imag,
      output m_valid, m_real, m_imag, m_index, m_last,
      input  m_ready
   );

   modport slave (
      input  ram_own, ram_rd_en, ram_addr,
      output ram_dout_real, ram_dout_imag,
      input  m_valid, m_real, m_imag, m_index, m_last,
      output m_ready
   );

endinterface

// File: rtl/cplx_fifo2.sv
// Two-entry synchronous FIFO holding complex bins with their index and last flag.
// Push while full is accepted only when a pop happens in the same cycle.
module cplx_fifo2
   import fft_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  fifo_entry_t i_data,
   input  logic        i_pop,
   output fifo_entry_t o_data,
   output logic        o_full,
   output logic        o_empty,
   output logic [1:0]  o_count
);

   fifo_entry_t r_mem [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic        w_do_push;
   logic        w_do_pop;

   assign o_full    = (r_count == 2'd2);
   assign o_empty   = (r_count == 2'd0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/fft_result_streamer.sv
// Unloads the FFT result RAM after fft_done rises and streams the bins out over valid/ready.
// Reads are credit-limited so the 2-entry buffer always has room for every read in flight.
module fft_result_streamer
   import fft_pkg::*;
#(
   parameter int unsigned N           = FFT_N,
   parameter int unsigned LOG2N       = FFT_LOG2N,
   parameter int unsigned DATA_W      = SAMPLE_W,
   parameter int unsigned BIT_REV_OUT = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fft_done,
   fft_result_streamer_if.master bus,
   output logic                  busy,
   output logic                  unload_done,
   output logic                  overrun
);

   localparam logic [LOG2N:0] CntN    = (LOG2N+1)'(N);
   localparam logic [LOG2N:0] CntLast = (LOG2N+1)'(N - 1);

   unload_state_e    r_state;
   logic             r_done_q;
   logic             r_busy;
   logic             r_own;
   logic             r_unload_done;
   logic             r_overrun;
   logic             r_inflight;
   logic             r_infl_last;
   logic [LOG2N:0]   r_rd_cnt;
   logic [LOG2N-1:0] r_infl_idx;
   logic [LOG2N-1:0] w_rd_addr;
   logic             w_start;
   logic             w_rd_en;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_last_xfer;
   logic [1:0]       w_count;
   logic [2:0]       w_level;
   fifo_entry_t      w_push_data;
   fifo_entry_t      w_head;

   assign w_start     = fft_done & ~r_done_q;
   assign w_pop       = ~w_empty & bus.m_ready;
   assign w_last_xfer = w_pop & w_head.last;
   // Buffer slots already spoken for after this cycle's pop.
   assign w_level     = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_rd_en     = (r_state == StStream) && (r_rd_cnt < CntN) && (w_level < 3'd2)
                        && !(w_full && !w_pop);
   assign w_rd_addr   = (BIT_REV_OUT != 0) ? bit_reverse(r_rd_cnt[LOG2N-1:0])
                                           : r_rd_cnt[LOG2N-1:0];

   always_comb begin
      w_push_data         = '0;
      w_push_data.data.re = bus.ram_dout_real;
      w_push_data.data.im = bus.ram_dout_imag;
      w_push_data.index   = r_infl_idx;
      w_push_data.last    = r_infl_last;
   end

   cplx_fifo2 u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_inflight),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= StIdle;
         r_done_q      <= 1'b0;
         r_busy        <= 1'b0;
         r_own         <= 1'b0;
         r_unload_done <= 1'b0;
         r_overrun     <= 1'b0;
         r_inflight    <= 1'b0;
         r_infl_last   <= 1'b0;
         r_infl_idx    <= '0;
         r_rd_cnt      <= '0;
      end else begin
         r_done_q      <= fft_done;
         r_unload_done <= 1'b0;
         r_inflight    <= w_rd_en;
         r_infl_idx    <= w_rd_addr;
         r_infl_last   <= (r_rd_cnt == CntLast);
         if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
         if (w_start && (r_state != StIdle)) r_overrun <= 1'b1;
         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_busy   <= 1'b1;
                  r_own    <= 1'b1;
                  r_rd_cnt <= '0;
                  r_state  <= StStream;
               end
            end
            StStream, StDrain: begin
               // The last bin can leave while still nominally streaming.
               if (w_last_xfer) begin
                  r_unload_done <= 1'b1;
                  r_busy        <= 1'b0;
                  r_own         <= 1'b0;
                  r_state       <= StIdle;
               end else if ((r_state == StStream) && (r_rd_cnt == CntN) && !r_inflight) begin
                  r_state <= StDrain;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.ram_own   = r_own;
   assign bus.ram_rd_en = w_rd_en;
   assign bus.ram_addr  = w_rd_addr;
   assign bus.m_valid   = ~w_empty;
   assign bus.m_real    = DATA_W'(w_head.data.re);
   assign bus.m_imag    = DATA_W'(w_head.data.im);
   assign bus.m_index   = w_head.index;
   assign bus.m_last    = w_head.last;
   assign busy          = r_busy;
   assign unload_done   = r_unload_done;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: natural and bit-reversed instances, RAM model and reference
// sequence of expected bins, cycle table for the stalled start, random backpressure runs.
module tb_fft_result_streamer;

   localparam int N     = 4096;
   localparam int LOG2N = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, fd, sel, m_ready;
   logic fd0, fd1, busy0, busy1, done0, done1, ovr0, ovr1;

   fft_result_streamer_if #(.LOG2N(LOG2N), .DATA_W(16)) bus0 ();
   fft_result_streamer_if #(.LOG2N(LOG2N), .DATA_W(16)) bus1 ();

   assign fd0 = fd & ~sel;
   assign fd1 = fd & sel;
   assign bus0.m_ready = m_ready;
   assign bus1.m_ready = m_ready;

   fft_result_streamer #(.N(N), .LOG2N(LOG2N), .DATA_W(16), .BIT_REV_OUT(0)) dut0 (
      .clk(clk), .reset(reset), .fft_done(fd0), .bus(bus0),
      .busy(busy0), .unload_done(done0), .overrun(ovr0)
   );

   fft_result_streamer #(.N(N), .LOG2N(LOG2N), .DATA_W(16), .BIT_REV_OUT(1)) dut1 (
      .clk(clk), .reset(reset), .fft_done(fd1), .bus(bus1),
      .busy(busy1), .unload_done(done1), .overrun(ovr1)
   );

   // RAM with one cycle of read latency
   logic [15:0] mem_re [N];
   logic [15:0] mem_im [N];
   always @(posedge clk) begin
      if (bus0.ram_rd_en) begin
         bus0.ram_dout_real <= mem_re[bus0.ram_addr];
         bus0.ram_dout_imag <= mem_im[bus0.ram_addr];
      end
      if (bus1.ram_rd_en) begin
         bus1.ram_dout_real <= mem_re[bus1.ram_addr];
         bus1.ram_dout_imag <= mem_im[bus1.ram_addr];
      end
   end

   // Observed instance
   logic        mv, mlast, mrd, mown, mbusy, mdone, movr;
   logic [15:0] mre, mim;
   logic [11:0] midx, maddr;
   assign mv    = sel ? bus1.m_valid   : bus0.m_valid;
   assign mlast = sel ? bus1.m_last    : bus0.m_last;
   assign mrd   = sel ? bus1.ram_rd_en : bus0.ram_rd_en;
   assign mown  = sel ? bus1.ram_own   : bus0.ram_own;
   assign mre   = sel ? bus1.m_real    : bus0.m_real;
   assign mim   = sel ? bus1.m_imag    : bus0.m_imag;
   assign midx  = sel ? bus1.m_index   : bus0.m_index;
   assign maddr = sel ? bus1.ram_addr  : bus0.ram_addr;
   assign mbusy = sel ? busy1 : busy0;
   assign mdone = sel ? done1 : done0;
   assign movr  = sel ? ovr1  : ovr0;

   int checks = 0;
   int errors = 0;
   int mk, issued, accepted, cyc, last_xfer_cyc, n_done, start_cyc;
   bit prev_stall, prev_rst;
   logic [63:0] prev_payload;

   typedef struct {
      bit ready;
      bit valid;
      bit rd_en;
      int addr;
      int idx;
   } row_t;
   row_t tbl [25];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_index(input int k, input bit brev);
      int r;
      if (!brev) return k;
      r = 0;
      for (int i = 0; i < LOG2N; i++) if (((k >> i) & 1) == 1) r = r | (1 << (LOG2N - 1 - i));
      return r;
   endfunction

   // Samples the observed instance mid-cycle and checks it against the expected bin order.
   task automatic sample();
      int e;
      @(negedge clk);
      cyc++;
      if (mrd) issued++;
      if (prev_stall && !prev_rst)
         chk("stall_hold", 64'({mv, midx, mre, mim, mlast}), prev_payload);
      if (mv && m_ready) begin
         accepted++;
         if (mk >= N) begin
            chk("extra_xfer", 64'(mk), 64'(N - 1));
         end else begin
            e = exp_index(mk, sel);
            chk("xfer_index", 64'(midx), 64'(e));
            chk("xfer_real", 64'(mre), 64'(mem_re[e]));
            chk("xfer_imag", 64'(mim), 64'(mem_im[e]));
            chk("xfer_last", 64'(mlast), 64'(mk == N - 1));
         end
         mk++;
         last_xfer_cyc = cyc;
      end
      if (issued - accepted > 2) chk("outstanding_le2", 64'(issued - accepted), 64'(2));
      if (mdone) begin
         n_done++;
         chk("done_delay", 64'(cyc - last_xfer_cyc), 64'(1));
         chk("done_after_all", 64'(mk), 64'(N));
      end
      prev_stall   = mv && !m_ready;
      prev_payload = 64'({mv, midx, mre, mim, mlast});
      prev_rst     = reset;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic start_unload(input bit s);
      sel = s;
      mk = 0; issued = 0; accepted = 0; n_done = 0; last_xfer_cyc = -100; prev_stall = 0;
      m_ready = 1'b1;
      fd = 1'b1;
      sample();
      start_cyc = cyc;
      adv();
      fd = 1'b0;
   endtask

   // mode 0: ready high + latency bound, 1: random ready, 2: ready high
   task automatic finish_unload(input int mode, input int ovr_at, input int rst_at);
      bit ovr_fired = 0;
      bit rst_fired = 0;
      int end_cyc = -1;
      for (int i = 0; i < 12000; i++) begin
         m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         fd = 1'b0;
         if (ovr_at >= 0 && !ovr_fired && mk == ovr_at) begin
            fd = 1'b1;
            ovr_fired = 1;
         end
         reset = 1'b0;
         if (rst_at >= 0 && !rst_fired && mk == rst_at) begin
            reset = 1'b1;
            rst_fired = 1;
         end
         sample();
         adv();
         if (reset) begin
            reset = 1'b0;
            fd = 1'b0;
            sample();
            chk("rst_m_valid", 64'(mv), 64'(0));
            chk("rst_busy", 64'(mbusy), 64'(0));
            chk("rst_ram_own", 64'(mown), 64'(0));
            chk("rst_unload_done", 64'(mdone), 64'(0));
            chk("rst_overrun", 64'(movr), 64'(0));
            adv();
            for (int j = 0; j < 10; j++) begin
               sample();
               adv();
            end
            chk("rst_no_done", 64'(n_done), 64'(0));
            return;
         end
         if (n_done > 0 && end_cyc < 0) end_cyc = cyc;
         if (end_cyc >= 0 && cyc >= end_cyc + 4) break;
      end
      fd = 1'b0;
      chk("all_bins", 64'(mk), 64'(N));
      chk("one_done", 64'(n_done), 64'(1));
      chk("idle_busy", 64'(mbusy), 64'(0));
      if (mode == 0) chk("latency_le_N3", 64'((last_xfer_cyc - start_cyc) <= N + 3), 64'(1));
      if (ovr_at >= 0) chk("overrun_set", 64'(movr), 64'(1));
   endtask

   initial begin
      // Startup with the sink stalled 20 cycles after the first sample
      tbl[0] = '{ready: 0, valid: 0, rd_en: 1, addr: 0, idx: 0};
      tbl[1] = '{ready: 0, valid: 0, rd_en: 1, addr: 1, idx: 0};
      for (int r = 2; r < 22; r++) tbl[r] = '{ready: 0, valid: 1, rd_en: 0, addr: 0, idx: 0};
      tbl[22] = '{ready: 1, valid: 1, rd_en: 1, addr: 2, idx: 0};
      tbl[23] = '{ready: 1, valid: 1, rd_en: 1, addr: 3, idx: 1};
      tbl[24] = '{ready: 1, valid: 1, rd_en: 1, addr: 4, idx: 2};

      for (int i = 0; i < N; i++) begin
         mem_re[i] = 16'(i);
         mem_im[i] = 16'(-i);
      end
      cyc = 0; mk = 0; issued = 0; accepted = 0; n_done = 0; last_xfer_cyc = -100;
      prev_stall = 0; prev_rst = 0; prev_payload = '0; start_cyc = 0;
      reset = 1'b1; fd = 1'b0; sel = 1'b0; m_ready = 1'b0;
      repeat (3) adv();
      reset = 1'b0;
      sample();
      chk("reset_valid0", 64'(bus0.m_valid), 64'(0));
      chk("reset_busy0", 64'(busy0), 64'(0));
      chk("reset_own0", 64'(bus0.ram_own), 64'(0));
      chk("reset_rd0", 64'(bus0.ram_rd_en), 64'(0));
      chk("reset_done0", 64'(done0), 64'(0));
      chk("reset_ovr0", 64'(ovr0), 64'(0));
      chk("reset_valid1", 64'(bus1.m_valid), 64'(0));
      chk("reset_busy1", 64'(busy1), 64'(0));
      chk("reset_own1", 64'(bus1.ram_own), 64'(0));
      adv();

      // Natural order, sink always ready
      start_unload(0);
      chk("start_busy", 64'(mbusy), 64'(1));
      chk("start_own", 64'(mown), 64'(1));
      finish_unload(0, -1, -1);

      // Stalled start, cycle by cycle
      start_unload(0);
      for (int r = 0; r < 25; r++) begin
         m_ready = tbl[r].ready;
         sample();
         chk($sformatf("tbl%0d_valid", r), 64'(mv), 64'(tbl[r].valid));
         chk($sformatf("tbl%0d_rd_en", r), 64'(mrd), 64'(tbl[r].rd_en));
         if (tbl[r].rd_en) chk($sformatf("tbl%0d_addr", r), 64'(maddr), 64'(tbl[r].addr));
         if (tbl[r].valid) chk($sformatf("tbl%0d_index", r), 64'(midx), 64'(tbl[r].idx));
         if (r == 21) chk("stall_two_reads", 64'(issued), 64'(2));
         adv();
      end
      finish_unload(2, -1, -1);

      // Bit-reversed instance
      start_unload(1);
      finish_unload(0, -1, -1);

      for (int i = 0; i < N; i++) begin
         mem_re[i] = 16'($urandom);
         mem_im[i] = 16'($urandom);
      end

      // Random backpressure
      start_unload(0);
      finish_unload(1, -1, -1);

      // Second edge during unload
      start_unload(0);
      finish_unload(2, 100, -1);

      // Reset mid-unload, then a clean restart from bin 0
      start_unload(0);
      finish_unload(2, -1, 500);
      start_unload(0);
      finish_unload(0, -1, -1);
      chk("restart_overrun_clear", 64'(movr), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
